// File: rtl/dla_axi_lite_m_seq.sv
// dla_axi_lite_m_seq: AXI-Lite manager with independent multi-beat read and write engines.
// Ports: clk_i/rstn_i; wr_cmd_* and rd_cmd_* take (base, len) commands when the engine is idle;
// wr_data_* / rd_data_* are valid/ready streams toward the DLA side; wr/rd_done_o pulse once per
// command with wr/rd_err_o flagging any non-OKAY response; pp_* is the AXI-Lite manager port.
module dla_axi_lite_m_seq #(
  parameter int AXI_ADDR_WIDTH  = 16,
  parameter int AXI_DATA_WIDTH  = 32,
  parameter int LEN_WIDTH       = 8,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                        clk_i,
  input  logic                        rstn_i,
  input  logic                        wr_cmd_valid_i,
  output logic                        wr_cmd_ready_o,
  input  logic [AXI_ADDR_WIDTH-1:0]   wr_addr_i,
  input  logic [LEN_WIDTH-1:0]        wr_len_i,
  input  logic [AXI_DATA_WIDTH-1:0]   wr_data_i,
  input  logic                        wr_data_valid_i,
  output logic                        wr_data_ready_o,
  output logic                        wr_done_o,
  output logic                        wr_err_o,
  input  logic                        rd_cmd_valid_i,
  output logic                        rd_cmd_ready_o,
  input  logic [AXI_ADDR_WIDTH-1:0]   rd_addr_i,
  input  logic [LEN_WIDTH-1:0]        rd_len_i,
  output logic [AXI_DATA_WIDTH-1:0]   rd_data_o,
  output logic                        rd_data_valid_o,
  input  logic                        rd_data_ready_i,
  output logic                        rd_done_o,
  output logic                        rd_err_o,
  output logic                        pp_awvalid_o,
  input  logic                        pp_awready_i,
  output logic [AXI_ADDR_WIDTH-1:0]   pp_awaddr_o,
  output logic [2:0]                  pp_awprot_o,
  output logic                        pp_wvalid_o,
  input  logic                        pp_wready_i,
  output logic [AXI_DATA_WIDTH-1:0]   pp_wdata_o,
  output logic [AXI_DATA_WIDTH/8-1:0] pp_wstrb_o,
  input  logic                        pp_bvalid_i,
  output logic                        pp_bready_o,
  input  logic [1:0]                  pp_bresp_i,
  output logic                        pp_arvalid_o,
  input  logic                        pp_arready_i,
  output logic [AXI_ADDR_WIDTH-1:0]   pp_araddr_o,
  output logic [2:0]                  pp_arprot_o,
  input  logic                        pp_rvalid_i,
  output logic                        pp_rready_o,
  input  logic [AXI_DATA_WIDTH-1:0]   pp_rdata_i,
  input  logic [1:0]                  pp_rresp_i
);
  localparam int CW = LEN_WIDTH + 1;
  localparam int OW = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [AXI_ADDR_WIDTH-1:0] STEP = AXI_ADDR_WIDTH'(AXI_DATA_WIDTH / 8);
  localparam logic [OW-1:0] MAX_OUT = OW'(MAX_OUTSTANDING);
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_e;
  state_e wr_st_q, wr_st_d, rd_st_q, rd_st_d;
  logic [AXI_ADDR_WIDTH-1:0] awaddr_q, awaddr_d, araddr_q, araddr_d;
  logic [CW-1:0] wr_beats_q, wr_beats_d, aw_cnt_q, aw_cnt_d, w_cnt_q, w_cnt_d, b_cnt_q, b_cnt_d;
  logic [CW-1:0] rd_beats_q, rd_beats_d, ar_cnt_q, ar_cnt_d, r_cnt_q, r_cnt_d;
  logic [OW-1:0] wr_out_q, wr_out_d, rd_out_q, rd_out_d;
  logic wr_err_q, wr_err_d, rd_err_q, rd_err_d, awvalid_q, awvalid_d, arvalid_q, arvalid_d;
  logic wr_cmd_hs, aw_hs, w_hs, b_hs, w_act, rd_cmd_hs, ar_hs, r_hs, r_act;
  assign pp_awvalid_o = awvalid_q;
  assign pp_awaddr_o  = awaddr_q;
  assign pp_awprot_o  = '0;
  assign pp_wdata_o   = wr_data_i;
  assign pp_wstrb_o   = '1;
  assign pp_arvalid_o = arvalid_q;
  assign pp_araddr_o  = araddr_q;
  assign pp_arprot_o  = '0;
  assign rd_data_o    = pp_rdata_i;
  // Write engine: W beats are counted separately from AW so data may run ahead of addresses.
  always_comb begin
    wr_cmd_ready_o  = wr_st_q == IDLE;
    wr_cmd_hs       = wr_cmd_valid_i & wr_cmd_ready_o;
    w_act           = wr_st_q == ISSUE && w_cnt_q < wr_beats_q;
    pp_wvalid_o     = wr_data_valid_i & w_act;
    wr_data_ready_o = pp_wready_i & w_act;
    pp_bready_o     = wr_st_q == ISSUE || wr_st_q == DRAIN;
    aw_hs           = awvalid_q & pp_awready_i;
    w_hs            = pp_wvalid_o & pp_wready_i;
    b_hs            = pp_bvalid_i & pp_bready_o;
    wr_beats_d      = wr_cmd_hs ? CW'(wr_len_i) + CW'(1) : wr_beats_q;
    awaddr_d        = wr_cmd_hs ? wr_addr_i : aw_hs ? awaddr_q + STEP : awaddr_q;
    aw_cnt_d        = wr_cmd_hs ? '0 : aw_cnt_q + CW'(aw_hs);
    w_cnt_d         = wr_cmd_hs ? '0 : w_cnt_q + CW'(w_hs);
    b_cnt_d         = wr_cmd_hs ? '0 : b_cnt_q + CW'(b_hs);
    wr_out_d        = wr_out_q + OW'(aw_hs) - OW'(b_hs);
    wr_err_d        = wr_cmd_hs ? 1'b0 : wr_err_q | (b_hs & |pp_bresp_i);
    // A pending AW holds; a new one is raised only from registered state, never from awready.
    awvalid_d       = (awvalid_q & ~pp_awready_i) |
                      (wr_st_q == ISSUE && aw_cnt_d < wr_beats_q && wr_out_d < MAX_OUT);
    wr_st_d         = wr_st_q == IDLE ? (wr_cmd_hs ? ISSUE : IDLE) :
                      wr_st_q == DONE ? IDLE :
                      b_cnt_d == wr_beats_q ? DONE :
                      (wr_st_q == ISSUE && aw_cnt_d == wr_beats_q && w_cnt_d == wr_beats_q) ? DRAIN :
                      wr_st_q;
    wr_done_o       = wr_st_q == DONE;
    wr_err_o        = wr_done_o & wr_err_q;
  end
  // Read engine: R data flows straight through to the consumer, so backpressure reaches RREADY.
  always_comb begin
    rd_cmd_ready_o  = rd_st_q == IDLE;
    rd_cmd_hs       = rd_cmd_valid_i & rd_cmd_ready_o;
    r_act           = rd_st_q == ISSUE || rd_st_q == DRAIN;
    rd_data_valid_o = pp_rvalid_i & r_act;
    pp_rready_o     = rd_data_ready_i & r_act;
    ar_hs           = arvalid_q & pp_arready_i;
    r_hs            = pp_rvalid_i & pp_rready_o;
    rd_beats_d      = rd_cmd_hs ? CW'(rd_len_i) + CW'(1) : rd_beats_q;
    araddr_d        = rd_cmd_hs ? rd_addr_i : ar_hs ? araddr_q + STEP : araddr_q;
    ar_cnt_d        = rd_cmd_hs ? '0 : ar_cnt_q + CW'(ar_hs);
    r_cnt_d         = rd_cmd_hs ? '0 : r_cnt_q + CW'(r_hs);
    rd_out_d        = rd_out_q + OW'(ar_hs) - OW'(r_hs);
    rd_err_d        = rd_cmd_hs ? 1'b0 : rd_err_q | (r_hs & |pp_rresp_i);
    arvalid_d       = (arvalid_q & ~pp_arready_i) |
                      (rd_st_q == ISSUE && ar_cnt_d < rd_beats_q && rd_out_d < MAX_OUT);
    rd_st_d         = rd_st_q == IDLE ? (rd_cmd_hs ? ISSUE : IDLE) :
                      rd_st_q == DONE ? IDLE :
                      r_cnt_d == rd_beats_q ? DONE :
                      (rd_st_q == ISSUE && ar_cnt_d == rd_beats_q) ? DRAIN :
                      rd_st_q;
    rd_done_o       = rd_st_q == DONE;
    rd_err_o        = rd_done_o & rd_err_q;
  end
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      wr_st_q    <= IDLE;
      rd_st_q    <= IDLE;
      awaddr_q   <= '0;
      araddr_q   <= '0;
      wr_beats_q <= '0;
      aw_cnt_q   <= '0;
      w_cnt_q    <= '0;
      b_cnt_q    <= '0;
      rd_beats_q <= '0;
      ar_cnt_q   <= '0;
      r_cnt_q    <= '0;
      wr_out_q   <= '0;
      rd_out_q   <= '0;
      wr_err_q   <= 1'b0;
      rd_err_q   <= 1'b0;
      awvalid_q  <= 1'b0;
      arvalid_q  <= 1'b0;
    end else begin
      wr_st_q    <= wr_st_d;
      rd_st_q    <= rd_st_d;
      awaddr_q   <= awaddr_d;
      araddr_q   <= araddr_d;
      wr_beats_q <= wr_beats_d;
      aw_cnt_q   <= aw_cnt_d;
      w_cnt_q    <= w_cnt_d;
      b_cnt_q    <= b_cnt_d;
      rd_beats_q <= rd_beats_d;
      ar_cnt_q   <= ar_cnt_d;
      r_cnt_q    <= r_cnt_d;
      wr_out_q   <= wr_out_d;
      rd_out_q   <= rd_out_d;
      wr_err_q   <= wr_err_d;
      rd_err_q   <= rd_err_d;
      awvalid_q  <= awvalid_d;
      arvalid_q  <= arvalid_d;
    end
  end
endmodule
